// File: rtl/usbdev_tx_sched.sv
// Packet scheduler in front of usb_fs_tx: arbitrates handshake vs IN data requests,
// issues the packet start, streams payload bytes and enforces the inter-packet gap.
module usbdev_tx_sched #(
  parameter int unsigned MinGapCycles  = 8,
  parameter int unsigned TimeoutCycles = 4096,
  parameter int unsigned MaxPktBytes   = 64,
  localparam int unsigned LenW         = $clog2(MaxPktBytes + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            link_reset_i,
  input  logic            hs_req_i,
  input  logic [3:0]      hs_pid_i,
  output logic            hs_ack_o,
  output logic            hs_done_o,
  input  logic            in_req_i,
  input  logic [3:0]      in_pid_i,
  input  logic [LenW-1:0] in_len_i,
  output logic            in_ack_o,
  output logic            in_done_o,
  input  logic [7:0]      in_data_i,
  output logic            in_data_get_o,
  output logic            tx_pkt_start_o,
  output logic [3:0]      tx_pid_o,
  output logic            tx_data_avail_o,
  output logic [7:0]      tx_data_o,
  input  logic            tx_data_get_i,
  input  logic            tx_pkt_end_i,
  output logic            busy_o,
  output logic            err_o
);

  localparam int unsigned ToW  = $clog2(TimeoutCycles);
  localparam int unsigned GapW = $clog2(MinGapCycles + 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TimeoutCycles - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(MinGapCycles - 1);
  localparam logic [LenW-1:0] LenMax  = LenW'(MaxPktBytes);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StSend,
    StGap
  } state_e;

  state_e          state_reg, state_next;
  logic            sel_in_reg, sel_in_next;
  logic [3:0]      pid_reg, pid_next;
  logic [LenW-1:0] bytes_left_reg, bytes_left_next;
  logic [ToW-1:0]  to_cnt_reg, to_cnt_next;
  logic [GapW-1:0] gap_cnt_reg, gap_cnt_next;
  logic            hs_done_reg, hs_done_next;
  logic            in_done_reg, in_done_next;
  logic            err_reg, err_next;
  logic [LenW-1:0] len_clamped;
  logic            payload_pending;

  // Out-of-range lengths are clipped so the byte counter can never overrun a packet.
  assign len_clamped     = (in_len_i > LenMax) ? LenMax : in_len_i;
  assign payload_pending = sel_in_reg && (bytes_left_reg != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= StIdle;
      sel_in_reg     <= 1'b0;
      pid_reg        <= 4'h0;
      bytes_left_reg <= '0;
      to_cnt_reg     <= '0;
      gap_cnt_reg    <= '0;
      hs_done_reg    <= 1'b0;
      in_done_reg    <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_in_reg     <= sel_in_next;
      pid_reg        <= pid_next;
      bytes_left_reg <= bytes_left_next;
      to_cnt_reg     <= to_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      hs_done_reg    <= hs_done_next;
      in_done_reg    <= in_done_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sel_in_next     = sel_in_reg;
    pid_next        = pid_reg;
    bytes_left_next = bytes_left_reg;
    to_cnt_next     = to_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    hs_done_next    = 1'b0;
    in_done_next    = 1'b0;
    err_next        = 1'b0;
    tx_pkt_start_o  = 1'b0;
    hs_ack_o        = 1'b0;
    in_ack_o        = 1'b0;
    tx_data_avail_o = 1'b0;
    tx_data_o       = 8'h00;
    in_data_get_o   = 1'b0;

    if (link_reset_i) begin
      state_next      = StIdle;
      sel_in_next     = 1'b0;
      pid_next        = 4'h0;
      bytes_left_next = '0;
      to_cnt_next     = '0;
      gap_cnt_next    = '0;
    end else begin
      unique case (state_reg)
        StIdle: begin
          if (hs_req_i) begin
            sel_in_next     = 1'b0;
            pid_next        = hs_pid_i;
            bytes_left_next = '0;
            state_next      = StStart;
          end else if (in_req_i) begin
            sel_in_next     = 1'b1;
            pid_next        = in_pid_i;
            bytes_left_next = len_clamped;
            state_next      = StStart;
          end
        end
        StStart: begin
          tx_pkt_start_o = 1'b1;
          hs_ack_o       = !sel_in_reg;
          in_ack_o       = sel_in_reg;
          to_cnt_next    = '0;
          state_next     = StSend;
        end
        StSend: begin
          tx_data_avail_o = payload_pending;
          tx_data_o       = in_data_i;
          in_data_get_o   = tx_data_get_i && payload_pending;
          if (in_data_get_o) begin
            bytes_left_next = bytes_left_reg - 1'b1;
          end
          // A pkt end arriving on the last timeout cycle still counts as a clean finish.
          if (tx_pkt_end_i || (to_cnt_reg == ToLast)) begin
            hs_done_next = !sel_in_reg;
            in_done_next = sel_in_reg;
            err_next     = !tx_pkt_end_i;
            gap_cnt_next = '0;
            state_next   = StGap;
          end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
          end
        end
        StGap: begin
          if (gap_cnt_reg == GapLast) begin
            state_next = StIdle;
          end else begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
          end
        end
        default: state_next = StIdle;
      endcase
    end
  end

  assign busy_o    = (state_reg != StIdle);
  assign tx_pid_o  = busy_o ? pid_reg : 4'h0;
  assign hs_done_o = hs_done_reg;
  assign in_done_o = in_done_reg;
  assign err_o     = err_reg;

endmodule

// File: tb/tb_usbdev_tx_sched.sv
// Directed bench for usbdev_tx_sched: handshake, data, tie, ZLP, timeout and link reset.
module tb_usbdev_tx_sched;

  localparam int unsigned MinGap  = 8;
  localparam int unsigned Timeout = 4096;
  localparam int unsigned MaxPkt  = 64;
  localparam int unsigned LenW    = $clog2(MaxPkt + 1);

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            link_reset_i;
  logic            hs_req_i;
  logic [3:0]      hs_pid_i;
  logic            hs_ack_o;
  logic            hs_done_o;
  logic            in_req_i;
  logic [3:0]      in_pid_i;
  logic [LenW-1:0] in_len_i;
  logic            in_ack_o;
  logic            in_done_o;
  logic [7:0]      in_data_i;
  logic            in_data_get_o;
  logic            tx_pkt_start_o;
  logic [3:0]      tx_pid_o;
  logic            tx_data_avail_o;
  logic [7:0]      tx_data_o;
  logic            tx_data_get_i;
  logic            tx_pkt_end_i;
  logic            busy_o;
  logic            err_o;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;
  int err_seen = 0;

  always #5 clk_i = ~clk_i;

  usbdev_tx_sched #(
    .MinGapCycles (MinGap),
    .TimeoutCycles(Timeout),
    .MaxPktBytes  (MaxPkt)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .link_reset_i   (link_reset_i),
    .hs_req_i       (hs_req_i),
    .hs_pid_i       (hs_pid_i),
    .hs_ack_o       (hs_ack_o),
    .hs_done_o      (hs_done_o),
    .in_req_i       (in_req_i),
    .in_pid_i       (in_pid_i),
    .in_len_i       (in_len_i),
    .in_ack_o       (in_ack_o),
    .in_done_o      (in_done_o),
    .in_data_i      (in_data_i),
    .in_data_get_o  (in_data_get_o),
    .tx_pkt_start_o (tx_pkt_start_o),
    .tx_pid_o       (tx_pid_o),
    .tx_data_avail_o(tx_data_avail_o),
    .tx_data_o      (tx_data_o),
    .tx_data_get_i  (tx_data_get_i),
    .tx_pkt_end_i   (tx_pkt_end_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  // Running tallies of completion and error pulses, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (hs_done_o || in_done_o) done_seen <= done_seen + 1;
    if (err_o) err_seen <= err_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, outputs are read 1ns later.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy_o && n < 200) begin
      step();
      #1;
      n++;
    end
    if (busy_o) check({tag, "_idle_timeout"}, 32'(busy_o), 32'd0);
  endtask

  task automatic pkt_end_pulse();
    step();
    tx_pkt_end_i = 1'b1;
    step();
    tx_pkt_end_i = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] bytes [3];
    int idx;
    int n;
    int base_done;
    int base_err;
    logic saw_avail;
    logic saw_get;
    logic early_ack;

    bytes[0] = 8'hA1;
    bytes[1] = 8'hB2;
    bytes[2] = 8'hC3;

    rst_ni        = 1'b0;
    link_reset_i  = 1'b0;
    hs_req_i      = 1'b0;
    hs_pid_i      = 4'h0;
    in_req_i      = 1'b0;
    in_pid_i      = 4'h0;
    in_len_i      = '0;
    in_data_i     = 8'h00;
    tx_data_get_i = 1'b0;
    tx_pkt_end_i  = 1'b0;

    // Reset state
    step();
    step();
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_pid", 32'(tx_pid_o), 32'd0);
    check("rst_start", 32'(tx_pkt_start_o), 32'd0);
    check("rst_outs", 32'({hs_ack_o, in_ack_o, hs_done_o, in_done_o, err_o, tx_data_avail_o}), 32'd0);
    rst_ni = 1'b1;
    step();

    // Handshake packet
    hs_req_i = 1'b1;
    hs_pid_i = 4'h2;
    #1;
    check("hs_grant_cycle_start", 32'(tx_pkt_start_o), 32'd0);
    step();
    #1;
    check("hs_start", 32'(tx_pkt_start_o), 32'd1);
    check("hs_ack", 32'(hs_ack_o), 32'd1);
    check("hs_in_ack", 32'(in_ack_o), 32'd0);
    check("hs_pid", 32'(tx_pid_o), 32'h2);
    hs_req_i = 1'b0;
    hs_pid_i = 4'hF;
    tx_data_get_i = 1'b1;
    step();
    #1;
    check("hs_avail", 32'(tx_data_avail_o), 32'd0);
    check("hs_pid_stable", 32'(tx_pid_o), 32'h2);
    check("hs_no_get", 32'(in_data_get_o), 32'd0);
    tx_data_get_i = 1'b0;
    pkt_end_pulse();
    check("hs_done", 32'(hs_done_o), 32'd1);
    check("hs_done_in", 32'(in_done_o), 32'd0);
    check("hs_no_err", 32'(err_o), 32'd0);
    wait_idle("hs", n);
    check("hs_gap_len", 32'(n), 32'(MinGap));
    $display("txn handshake pid=2 gap=%0d", n);

    // Data packet of three bytes
    in_req_i = 1'b1;
    in_pid_i = 4'h3;
    in_len_i = LenW'(3);
    step();
    #1;
    check("dat_start", 32'(tx_pkt_start_o), 32'd1);
    check("dat_ack", 32'(in_ack_o), 32'd1);
    check("dat_hs_ack", 32'(hs_ack_o), 32'd0);
    check("dat_pid", 32'(tx_pid_o), 32'h3);
    in_req_i = 1'b0;
    in_len_i = LenW'(7);
    in_pid_i = 4'h9;
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      in_data_i     = (idx < 3) ? bytes[idx] : 8'h00;
      tx_data_get_i = (k % 2 == 0);
      #1;
      if (tx_data_avail_o) check("dat_byte", 32'(tx_data_o), 32'(bytes[idx]));
      if (in_data_get_o) idx++;
    end
    check("dat_get_count", 32'(idx), 32'd3);
    check("dat_avail_end", 32'(tx_data_avail_o), 32'd0);
    check("dat_pid_stable", 32'(tx_pid_o), 32'h3);
    tx_data_get_i = 1'b0;
    pkt_end_pulse();
    check("dat_done", 32'(in_done_o), 32'd1);
    check("dat_done_hs", 32'(hs_done_o), 32'd0);
    wait_idle("dat", n);
    $display("txn data pid=3 len=3 gets=%0d", idx);

    // Tie: handshake wins, data waits out the gap
    hs_req_i = 1'b1;
    hs_pid_i = 4'hA;
    in_req_i = 1'b1;
    in_pid_i = 4'hB;
    in_len_i = LenW'(1);
    step();
    #1;
    check("tie_hs_ack", 32'(hs_ack_o), 32'd1);
    check("tie_in_ack", 32'(in_ack_o), 32'd0);
    check("tie_pid", 32'(tx_pid_o), 32'hA);
    hs_req_i = 1'b0;
    pkt_end_pulse();
    check("tie_hs_done", 32'(hs_done_o), 32'd1);
    n = 0;
    early_ack = 1'b0;
    while (busy_o && n < 200) begin
      step();
      #1;
      n++;
      if (in_ack_o) early_ack = 1'b1;
    end
    check("tie_gap_len", 32'(n), 32'(MinGap));
    check("tie_gap_ignored", 32'(early_ack), 32'd0);
    step();
    #1;
    check("tie_in_grant", 32'(in_ack_o), 32'd1);
    check("tie_in_pid", 32'(tx_pid_o), 32'hB);
    in_req_i = 1'b0;
    pkt_end_pulse();
    check("tie_in_done", 32'(in_done_o), 32'd1);
    wait_idle("tie", n);
    $display("txn tie hs_then_in gap=%0d", MinGap);

    // Zero-length data packet
    in_req_i = 1'b1;
    in_pid_i = 4'hB;
    in_len_i = '0;
    step();
    #1;
    check("zlp_ack", 32'(in_ack_o), 32'd1);
    in_req_i = 1'b0;
    tx_data_get_i = 1'b1;
    saw_avail = 1'b0;
    saw_get = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      if (tx_data_avail_o) saw_avail = 1'b1;
      if (in_data_get_o) saw_get = 1'b1;
    end
    check("zlp_avail", 32'(saw_avail), 32'd0);
    check("zlp_get", 32'(saw_get), 32'd0);
    tx_data_get_i = 1'b0;
    pkt_end_pulse();
    check("zlp_done", 32'(in_done_o), 32'd1);
    wait_idle("zlp", n);
    $display("txn zlp pid=b");

    // Timeout: transmitter never ends the packet
    in_req_i = 1'b1;
    in_pid_i = 4'h3;
    in_len_i = LenW'(2);
    step();
    #1;
    check("to_start", 32'(tx_pkt_start_o), 32'd1);
    in_req_i = 1'b0;
    n = 0;
    while (!err_o && n < Timeout + 50) begin
      step();
      #1;
      n++;
    end
    check("to_err_latency", 32'(n), 32'(Timeout + 1));
    check("to_done", 32'(in_done_o), 32'd1);
    wait_idle("to", n);
    $display("txn timeout err after %0d cycles", Timeout + 1);

    // Pkt end on the final timeout cycle: clean finish, no err
    in_req_i = 1'b1;
    step();
    #1;
    check("tol_start", 32'(tx_pkt_start_o), 32'd1);
    in_req_i = 1'b0;
    for (int k = 0; k < Timeout - 1; k++) step();
    pkt_end_pulse();
    check("tol_done", 32'(in_done_o), 32'd1);
    check("tol_no_err", 32'(err_o), 32'd0);
    wait_idle("tol", n);
    $display("txn timeout_edge pkt_end wins");

    // Link reset in the middle of Send
    in_req_i = 1'b1;
    step();
    #1;
    check("lr_start", 32'(tx_pkt_start_o), 32'd1);
    in_req_i = 1'b0;
    step();
    step();
    base_done = done_seen;
    base_err = err_seen;
    link_reset_i = 1'b1;
    step();
    link_reset_i = 1'b0;
    #1;
    check("lr_busy", 32'(busy_o), 32'd0);
    check("lr_pid", 32'(tx_pid_o), 32'd0);
    for (int k = 0; k < 10; k++) step();
    check("lr_no_done", 32'(done_seen - base_done), 32'd0);
    check("lr_no_err", 32'(err_seen - base_err), 32'd0);
    $display("txn link_reset mid-send");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
